// File: rtl/clk_gen_pkg.sv
`default_nettype none
// =============================================================================
// Module   : clk_gen_pkg
// Brief    : Shared width, counter type and terminal-count decode for clk_gen.
// Revision : 1.0 - initial release
// =============================================================================
package clk_gen_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

    // Unsigned >= so a limit lowered below the running count still forces a wrap
    function automatic logic is_term(input cnt_t count, input cnt_t limit, input logic en);
        return en && (count >= limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_counter.sv
`default_nettype none
// =============================================================================
// Module   : tc_counter
// Brief    : Enabled up-counter that wraps to zero at or beyond a terminal count.
// Revision : 1.0 - initial release
// =============================================================================
module tc_counter
    import clk_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             w_term;

    generate
        if (WIDTH <= DEFAULT_WIDTH) begin : g_pkg_term
            assign w_term = is_term(cnt_t'(r_count), cnt_t'(limit), en);
        end else begin : g_wide_term
            assign w_term = en && (r_count >= limit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_term) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;
    assign term  = w_term;

endmodule
`default_nettype wire

// File: rtl/clk_gen_counter.sv
`default_nettype none
// =============================================================================
// Module   : clk_gen_counter
// Brief    : Programmable divider; clk_0 toggles on every counter wrap.
//            Optional registered tick output under CLK_GEN_TICK_OUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module clk_gen_counter
    import clk_gen_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter logic CLK0_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
`ifdef CLK_GEN_TICK_OUT_EN
    output logic             tick,
`endif
    output logic             clk_0
);

    logic w_term;
    logic r_clk_0;

    tc_counter #(
        .WIDTH (WIDTH)
    ) u_tc_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .limit (limit),
        .count (count),
        .term  (w_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_0 <= CLK0_INIT;
        end else if (w_term) begin
            r_clk_0 <= ~r_clk_0;
        end
    end

    assign clk_0 = r_clk_0;

`ifdef CLK_GEN_TICK_OUT_EN
    // Lands with the count returning to zero and the clk_0 edge
    logic r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_term;
        end
    end

    assign tick = r_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_counter.sv
`default_nettype none
// =============================================================================
// Module   : tb_clk_gen_counter
// Brief    : Directed scoreboard bench for clk_gen_counter (WIDTH=32, CLK0_INIT=0).
// Revision : 1.0 - initial release
// =============================================================================
module tb_clk_gen_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] limit;
    wire  [31:0] count;
    wire         clk_0;
`ifdef CLK_GEN_TICK_OUT_EN
    wire         tick;
`endif

    clk_gen_counter #(
        .WIDTH     (32),
        .CLK0_INIT (1'b0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .limit (limit),
        .count (count),
`ifdef CLK_GEN_TICK_OUT_EN
        .tick  (tick),
`endif
        .clk_0 (clk_0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        c0;
        logic        tk;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_cnt  = '0;
    logic        m_c0   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one edge, push the model's expectation, then pop and compare after the edge
    task automatic cycle(input logic r, input logic e, input logic [31:0] l, input string tag);
        exp_t x;
        logic t;
        rst   = r;
        en    = e;
        limit = l;
        if (r) begin
            m_cnt = '0;
            m_c0  = 1'b0;
            t     = 1'b0;
        end else begin
            t = e && (m_cnt >= l);
            if (t) begin
                m_cnt = '0;
                m_c0  = ~m_c0;
            end else if (e) begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        x.cnt = m_cnt;
        x.c0  = m_c0;
        x.tk  = t;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk({tag, ".count"}, count, x.cnt);
        chk({tag, ".clk_0"}, {31'd0, clk_0}, {31'd0, x.c0});
`ifdef CLK_GEN_TICK_OUT_EN
        chk({tag, ".tick"}, {31'd0, tick}, {31'd0, x.tk});
`endif
    endtask

    task automatic run(input int n, input logic e, input logic [31:0] l, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, e, l, tag);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        limit = 32'd5;

        // Reset held with en=1 must keep everything at reset values
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'd5, "reset");
        chk("reset_cnt", count, 32'd0);
        chk("reset_clk0", {31'd0, clk_0}, 32'd0);

        // Divide by 512: rise after 256 enabled edges, 50% duty
        run(10, 1'b0, 32'hFF, "idle");
        run(255, 1'b1, 32'hFF, "div_ramp");
        chk("div_top_cnt", count, 32'hFF);
        chk("div_pre_rise", {31'd0, clk_0}, 32'd0);
        run(1, 1'b1, 32'hFF, "div_wrap");
        chk("div_rise", {31'd0, clk_0}, 32'd1);
        chk("div_wrap_cnt", count, 32'd0);
        run(256, 1'b1, 32'hFF, "div_high");
        chk("div_fall", {31'd0, clk_0}, 32'd0);
        run(256, 1'b1, 32'hFF, "div_low");
        chk("div_rise2", {31'd0, clk_0}, 32'd1);

        // limit=0: toggle every enabled edge, count pinned at 0
        cycle(1'b1, 1'b0, 32'd0, "min_rst");
        for (int i = 0; i < 6; i++) begin
            run(1, 1'b1, 32'd0, "min");
            chk("min_toggle", {31'd0, clk_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("min_cnt", count, 32'd0);
        end

        // Enable gap at count 4; wrap lands 6 enabled edges after resume
        cycle(1'b1, 1'b0, 32'd9, "gap_rst");
        run(4, 1'b1, 32'd9, "gap_pre");
        run(7, 1'b0, 32'd9, "gap_hold");
        chk("gap_held_cnt", count, 32'd4);
        chk("gap_held_clk0", {31'd0, clk_0}, 32'd0);
        run(5, 1'b1, 32'd9, "gap_resume");
        chk("gap_no_toggle", {31'd0, clk_0}, 32'd0);
        run(1, 1'b1, 32'd9, "gap_wrap");
        chk("gap_toggle", {31'd0, clk_0}, 32'd1);

        // Limit lowered below count: immediate wrap, then 42-cycle period
        cycle(1'b1, 1'b0, 32'd100, "lim_rst");
        run(50, 1'b1, 32'd100, "lim_up");
        chk("lim_at50", count, 32'd50);
        run(1, 1'b1, 32'd20, "lim_drop");
        chk("lim_drop_cnt", count, 32'd0);
        chk("lim_drop_clk0", {31'd0, clk_0}, 32'd1);
        run(21, 1'b1, 32'd20, "lim_half1");
        chk("lim_half1", {31'd0, clk_0}, 32'd0);
        run(21, 1'b1, 32'd20, "lim_half2");
        chk("lim_half2", {31'd0, clk_0}, 32'd1);

        // Limit raised mid-run: keeps counting past the old limit
        run(5, 1'b1, 32'd20, "raise_pre");
        run(30, 1'b1, 32'd40, "raise");
        chk("raise_cnt", count, 32'd35);

        // Reset mid-run at count=2, clk_0=1
        cycle(1'b1, 1'b0, 32'd3, "mid_rst0");
        run(6, 1'b1, 32'd3, "mid_pre");
        chk("mid_pre_cnt", count, 32'd2);
        chk("mid_pre_clk0", {31'd0, clk_0}, 32'd1);
        cycle(1'b1, 1'b1, 32'd3, "mid_rst");
        chk("mid_rst_cnt", count, 32'd0);
        chk("mid_rst_clk0", {31'd0, clk_0}, 32'd0);
        run(4, 1'b1, 32'd3, "mid_restart");
        chk("mid_restart_clk0", {31'd0, clk_0}, 32'd1);

        // Full-width unsigned compare with a high limit
        run(3, 1'b1, 32'hFFFF_FFFF, "allones");
        chk("allones_cnt", count, 32'd3);

        chk("sb_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
